pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It detects load-use hazards in ID, applies branch redirect flushes from EX, and freezes the whole pipeline while the data memory holds off a MEM-stage access, with a timeout to a sticky error state. Its `idex_bubble_o` drives the `hazard_i` input of the ID/EX control mux. It also drives the write enables of the PC and of every stage register, and keeps saturating stall and flush counters for performance reporting.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: consecutive memory-stalled cycles that trigger the error; legal range ≥ 2.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; asynchronous and active-high
- `id_rs1_i` / `id_rs2_i`  in  5 each  source registers of the instruction in ID
- `id_use_rs1_i` / `id_use_rs2_i`  in  1 each  the ID instruction actually reads rs1 / rs2
- `ex_rd_i`  in  5  destination register of the instruction in EX
- `ex_memr_i`  in  1  the EX instruction is a load
- `ex_br_taken_i`  in  1  EX resolves a taken branch or jump (redirect)
- `mem_req_i`  in  1  MEM stage has an active data-memory access
- `mem_ready_i`  in  1  data memory completes the access this cycle
- `pc_we_o`, `ifid_we_o`, `idex_we_o`, `exmem_we_o`, `memwb_we_o`  out  1 each  stage-register write enables
- `ifid_flush_o`  out  1  load NOP into IF/ID
- `idex_bubble_o`  out  1  zero the ID/EX control fields
- `memwb_bubble_o`  out  1  zero the MEM/WB control fields
- `mem_err_o`  out  1  sticky memory timeout flag
- `stall_cnt_o`  out  CNT_W  stalled-cycle count
- `flush_cnt_o`  out  CNT_W  redirect count

## Operation
- FSM states are `RUN`, `MEM_WAIT` and `ERR`; the reset state is `RUN`.
- Hazard decode is combinational from the inputs and the state. Response is in the same cycle, with fixed priority: memory freeze > redirect > load-use.
- Memory freeze applies when `mem_req_i & ~mem_ready_i` in `RUN` or `MEM_WAIT`:
  - All `*_we_o` are 0 and `memwb_bubble_o` is 1.
  - `ifid_flush_o` and `idex_bubble_o` are 0.
  - `RUN` moves to `MEM_WAIT`, with `wait_cnt` set to 1.
- In `MEM_WAIT`:
  - If `mem_ready_i` is 1, the normal priority evaluation applies that cycle and the next state is `RUN`.
  - Otherwise the freeze is held and `wait_cnt` increments.
  - When `wait_cnt == MEM_TIMEOUT-1` and ready is still low, the next state is `ERR`.
- Redirect (`ex_br_taken_i`, not frozen):
  - `ifid_flush_o` is 1 and `idex_bubble_o` is 1; all write enables are 1.
  - `flush_cnt` increments.
  - A redirect held during a freeze is applied on the release cycle only.
- Load-use condition: `ex_memr_i & (ex_rd_i != 0) & ((id_use_rs1_i & id_rs1_i == ex_rd_i) | (id_use_rs2_i & id_rs2_i == ex_rd_i))`.
  - Response when not frozen and no redirect: `pc_we_o` is 0, `ifid_we_o` is 0 and `idex_bubble_o` is 1; the other write enables are 1.
  - This yields exactly one bubble, because the load has left EX on the next cycle.
- With no hazard, all write enables are 1 and all flush/bubble outputs are 0.
- `stall_cnt` increments on every freeze cycle and every load-use cycle. Both counters saturate at all-ones.
- In `ERR`:
  - All write enables are 0, `memwb_bubble_o` is 1 and `mem_err_o` is 1.
  - Inputs are ignored and the counters are frozen.
  - Exit is by reset only.
- Reset values of the registered state: state `RUN`, `wait_cnt` 0, `mem_err_o` 0, both counters 0.
- Combinational outputs during reset: all write enables 1, all flush/bubble outputs 0.

## Timing
- Stall, flush and bubble outputs have zero latency: they are combinational from the inputs and the state.
- `mem_err_o` rises on the clock edge that ends the `MEM_TIMEOUT`-th consecutive stalled cycle.
- Counters update on the clock edge ending the qualifying cycle, so they are visible one cycle later.
- Reset asserted mid-`MEM_WAIT` or in `ERR` returns the block to `RUN` immediately (asynchronously); `wait_cnt` and the error flag clear.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state enum `hz_state_e {RUN, MEM_WAIT, ERR}`
  - constant `REG_X0 = 5'd0`
- Sub-module `load_use_detect`: pure combinational comparator producing the load-use condition. It is reusable by a future forwarding unit.
- The top level holds the FSM, `wait_cnt` (width `$clog2(MEM_TIMEOUT)+1`) and the two counters.

## Test plan
- Load-use:
  - Stimulus: `ex_memr_i=1`, `ex_rd_i=5`, `id_rs2_i=5`, `id_use_rs2_i=1`.
  - Response: one cycle with `pc_we_o=0`, `ifid_we_o=0`, `idex_bubble_o=1`; `stall_cnt_o` reads 1 afterwards.
- Same stimulus with `ex_rd_i=0`, or with `id_use_rs2_i=0`: no stall, all write enables 1.
- Redirect plus load-use in the same cycle:
  - Response: `ifid_flush_o=1`, `idex_bubble_o=1`, `pc_we_o=1`.
  - `flush_cnt_o` increments and `stall_cnt_o` is unchanged.
- Memory wait of 3 cycles, with `ex_br_taken_i=1` held throughout:
  - During the wait: 3 frozen cycles with all write enables 0 and `memwb_bubble_o=1`, no flush.
  - On the ready cycle: flush asserted and the FSM returns to `RUN`; `stall_cnt_o` increases by 3.
- `mem_ready_i` held low forever with `MEM_TIMEOUT=16`:
  - `mem_err_o` rises after 16 stalled cycles and stays 1 after `mem_ready_i` rises.
- Reset pulse asserted in cycle 5 of a memory wait: state returns to `RUN`, counters read 0 and `mem_err_o` is 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} hz_state_e;
    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rd,
    input  logic       memr,
    output logic       hazard
);
    assign hazard = memr & (rd != REG_X0) &
                    ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer with memory freeze, redirect flush, load-use bubble,
// memory timeout error and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memr_i,
    input  logic             ex_br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             idex_we_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             memwb_bubble_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;

    hz_state_e state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic load_use, freeze, redirect, stall_use;

    load_use_detect u_lud (
        .rs1     (id_rs1_i),
        .rs2     (id_rs2_i),
        .use_rs1 (id_use_rs1_i),
        .use_rs2 (id_use_rs2_i),
        .rd      (ex_rd_i),
        .memr    (ex_memr_i),
        .hazard  (load_use)
    );

    // Once waiting, the freeze holds until ready regardless of the request line.
    assign freeze    = ((state == RUN) & mem_req_i & ~mem_ready_i) |
                       ((state == MEM_WAIT) & ~mem_ready_i);
    assign redirect  = (state != ERR) & ~freeze & ex_br_taken_i;
    assign stall_use = (state != ERR) & ~freeze & ~ex_br_taken_i & load_use;
    assign mem_err_o = (state == ERR);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = ERR;
        endcase
    end

    always_comb begin
        pc_we_o        = 1'b1;
        ifid_we_o      = 1'b1;
        idex_we_o      = 1'b1;
        exmem_we_o     = 1'b1;
        memwb_we_o     = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        if (!rst_i) begin
            if (state == ERR || freeze) begin
                pc_we_o        = 1'b0;
                ifid_we_o      = 1'b0;
                idex_we_o      = 1'b0;
                exmem_we_o     = 1'b0;
                memwb_we_o     = 1'b0;
                memwb_bubble_o = 1'b1;
            end else if (redirect) begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (stall_use) begin
                pc_we_o       = 1'b0;
                ifid_we_o     = 1'b0;
                idex_bubble_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if ((freeze || stall_use) && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (redirect && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven hazard decode vectors plus hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic u1 = 1'b0, u2 = 1'b0, memr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, memwb_bubble, mem_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [7:0] outs;
    int errors = 0, checks = 0;
    int m_stall = 0, m_flush = 0;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic u1, u2;
        logic [4:0] rd;
        logic memr, br, req, rdy;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[9];

    // exp = {pc, ifid, idex, exmem, memwb write enables, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [7:0] O_IDLE = 8'b11111_000, O_LU = 8'b00111_010,
                           O_RED = 8'b11111_110, O_FRZ = 8'b00000_001;

    always #5 clk = ~clk;
    assign outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, memwb_bubble};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1), .id_use_rs2_i(u2),
        .ex_rd_i(rd), .ex_memr_i(memr), .ex_br_taken_i(br),
        .mem_req_i(req), .mem_ready_i(rdy),
        .pc_we_o(pc_we), .ifid_we_o(ifid_we), .idex_we_o(idex_we),
        .exmem_we_o(exmem_we), .memwb_we_o(memwb_we),
        .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble), .memwb_bubble_o(memwb_bubble),
        .mem_err_o(mem_err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; memr = 0; br = 0; req = 0; rdy = 0;
    endtask

    task automatic set_lu();
        rs2 = 5'd5; u2 = 1; rd = 5'd5; memr = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE};
        vecs[1] = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, O_LU};
        vecs[2] = '{5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, O_IDLE};
        vecs[3] = '{5'd0, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0, O_IDLE};
        vecs[4] = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, O_LU};
        vecs[5] = '{5'd7, 5'd0, 1, 0, 5'd7, 0, 0, 0, 0, O_IDLE};
        vecs[6] = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, O_RED};
        vecs[7] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, O_RED};
        vecs[8] = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 1, 1, O_LU};

        // reset: hazard inputs present but outputs forced to pass-through
        set_lu(); br = 1;
        #12;
        chk("reset_outs", 32'(outs), 32'(O_IDLE));
        chk("reset_err", 32'(mem_err), 0);
        chk("reset_stall", 32'(stall_cnt), 0);
        chk("reset_flush", 32'(flush_cnt), 0);
        @(negedge clk);
        rst = 0; idle();
        #1;

        for (int i = 0; i < 9; i++) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; u1 = vecs[i].u1; u2 = vecs[i].u2;
            rd = vecs[i].rd; memr = vecs[i].memr; br = vecs[i].br;
            req = vecs[i].req; rdy = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(m_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_cnt), 32'(m_flush));
            if (!vecs[i].exp[7]) m_stall++;
            if (vecs[i].exp[2]) m_flush++;
            step();
        end
        idle(); #1;
        chk("table_stall_after", 32'(stall_cnt), 32'(m_stall));
        chk("table_flush_after", 32'(flush_cnt), 32'(m_flush));

        // 3-cycle memory wait with a redirect held throughout
        req = 1; rdy = 0; br = 1; set_lu();
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("wait%0d_outs", c), 32'(outs), 32'(O_FRZ));
            step();
        end
        rdy = 1; #1;
        chk("wait_release_outs", 32'(outs), 32'(O_RED));
        step();
        idle(); #1;
        chk("wait_back_run", 32'(outs), 32'(O_IDLE));
        chk("wait_stall", 32'(stall_cnt), 32'(m_stall + 3));
        chk("wait_flush", 32'(flush_cnt), 32'(m_flush + 1));

        // timeout: ready never arrives
        rst = 1; #1; rst = 0;
        @(negedge clk); #1;
        chk("pre_timeout_stall", 32'(stall_cnt), 0);
        req = 1; rdy = 0;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("timeout_err_c%0d", c), 32'(mem_err), 0);
            step();
        end
        chk("timeout_err_set", 32'(mem_err), 1);
        rdy = 1; req = 0; set_lu(); br = 1; #1;
        chk("err_outs", 32'(outs), 32'(O_FRZ));
        step();
        chk("err_sticky", 32'(mem_err), 1);
        chk("err_stall_frozen", 32'(stall_cnt), 16);
        chk("err_flush_frozen", 32'(flush_cnt), 0);

        // reset clears the error state asynchronously
        rst = 1; #1;
        chk("err_reset_clear", 32'(mem_err), 0);
        @(negedge clk); rst = 0; idle(); #1;

        // reset pulse in cycle 5 of a memory wait
        req = 1; rdy = 0; br = 0;
        for (int c = 0; c < 4; c++) step();
        chk("midwait_stall", 32'(stall_cnt), 4);
        rst = 1; #1;
        chk("midwait_rst_stall", 32'(stall_cnt), 0);
        chk("midwait_rst_flush", 32'(flush_cnt), 0);
        chk("midwait_rst_err", 32'(mem_err), 0);
        @(negedge clk); rst = 0; idle(); #1;
        chk("midwait_run_outs", 32'(outs), 32'(O_IDLE));
        step();
        chk("midwait_run_stall", 32'(stall_cnt), 0);
        req = 1; rdy = 0; #1;
        chk("refreeze_outs", 32'(outs), 32'(O_FRZ));
        step();
        rdy = 1; #1;
        chk("refreeze_release", 32'(outs), 32'(O_IDLE));
        step();
        chk("refreeze_stall", 32'(stall_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
